// File: rtl/led_axi_lite_slave_regs.sv
// AXI4-Lite responder for the LED peripheral: four 32-bit R/W registers,
// independent write and read channels, LEDs driven from slv_reg0.
module led_axi_lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            LED
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int NB       = DW / 8;
  localparam int NUM_REGS = 4;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]                    aw_idx_q, wr_idx;
  logic [DW-1:0]                 wdata_q, wr_data, rdata_q;
  logic [NB-1:0]                 wstrb_q, wr_strb;
  logic [NUM_REGS-1:0]           wr_sel;
  logic [NUM_REGS-1:0][DW-1:0]   slv_reg;
  logic                          unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign S_AXI_WREADY  = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = !ARESET && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign LED           = slv_reg[0][LED_WIDTH-1:0];

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_next = W_RESP;
      W_HAVE_W:  if (aw_hs) w_next = W_RESP;
      W_RESP:    if (S_AXI_BVALID && S_AXI_BREADY) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Whichever half arrives last is taken straight from the bus on the commit edge.
  assign commit  = (w_state != W_RESP) && (w_next == W_RESP);
  assign wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
  assign wr_data = w_hs  ? S_AXI_WDATA : wdata_q;
  assign wr_strb = w_hs  ? S_AXI_WSTRB : wstrb_q;
  assign wr_sel  = commit ? (NUM_REGS'(1) << wr_idx) : '0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      slv_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        for (int b = 0; b < NB; b++)
          if (wr_sel[r] && wr_strb[b]) slv_reg[r][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (S_AXI_RVALID && S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Samples pre-commit register contents, so a colliding read sees the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= slv_reg[S_AXI_ARADDR[3:2]];
  end

endmodule

// File: tb/tb_led_axi_lite_slave_regs.sv
// Self-checking bench for led_axi_lite_slave_regs: vector table, corner
// sequences and random traffic against an array-based register model.
module tb_led_axi_lite_slave_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB, LED;
  logic [1:0]  BRESP, RRESP;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [4];

  led_axi_lite_slave_regs dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write with independent AW/W start delays; hold = cycles of BREADY low.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int hold);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int cyc = 0;
    AWADDR = a; WDATA = d; WSTRB = s; BREADY = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done  && (cyc >= w_dly);
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      step();
      aw_done |= aw_f; w_done |= w_f; cyc++;
      if (aw_done && !w_done) chk("awready_after_aw", {31'd0, AWREADY}, 32'd0);
      if (w_done && !aw_done) chk("wready_after_w", {31'd0, WREADY}, 32'd0);
    end
    AWVALID = 0; WVALID = 0;
    chk("write_handshakes", {31'd0, aw_done && w_done}, 32'd1);
    chk("bvalid_latency", {31'd0, BVALID}, 32'd1);
    chk("bresp", {30'd0, BRESP}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      AWADDR = a ^ 4'h4; WDATA = ~d; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
      step();
      chk("bvalid_hold", {31'd0, BVALID}, 32'd1);
      chk("awready_in_resp", {31'd0, AWREADY}, 32'd0);
      chk("wready_in_resp", {31'd0, WREADY}, 32'd0);
    end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    step();
    chk("bvalid_clear", {31'd0, BVALID}, 32'd0);
    BREADY = 0;
    if (aw_done && w_done)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] d);
    bit fired = 0;
    int cyc = 0;
    ARADDR = a; ARVALID = 1; RREADY = 0;
    while (!fired && cyc < 40) begin
      fired = ARREADY;
      step();
      cyc++;
    end
    ARVALID = 0;
    chk("rvalid_latency", {31'd0, RVALID}, 32'd1);
    chk("rresp", {30'd0, RRESP}, 32'd0);
    d = RDATA;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rvalid_hold", {31'd0, RVALID}, 32'd1);
      chk("rdata_stable", RDATA, d);
    end
    RREADY = 1;
    step();
    chk("rvalid_clear", {31'd0, RVALID}, 32'd0);
    RREADY = 0;
  endtask

  task automatic read_check(input logic [3:0] a, input int hold);
    logic [31:0] d;
    axi_read(a, hold, d);
    chk("rdata_model", d, model[a[3:2]]);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] d;
    vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 0, 0, 32'h0000_0001};
    vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 0, 0, 32'h0000_0002};
    vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 0, 0, 32'h0000_0003};
    vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 0, 0, 32'h0000_0004};
    vecs[4] = '{4'h4, 32'h1122_3344, 4'hF, 0, 0, 32'h1122_3344};
    vecs[5] = '{4'h4, 32'hAABB_CCDD, 4'h5, 0, 0, 32'h11BB_33DD};
    vecs[6] = '{4'h8, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'hDEAD_BEEF};
    vecs[7] = '{4'hC, 32'hCAFE_F00D, 4'hF, 0, 2, 32'hCAFE_F00D};
    vecs[8] = '{4'h7, 32'h0000_FFFF, 4'h3, 1, 1, 32'h11BB_FFFF};
    vecs[9] = '{4'h1, 32'h1234_5678, 4'h8, 0, 0, 32'h1200_0001};

    rst = 1; AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0; WDATA = 0; WSTRB = 0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (5) step();
    chk("rst_awready", {31'd0, AWREADY}, 32'd0);
    chk("rst_wready", {31'd0, WREADY}, 32'd0);
    chk("rst_arready", {31'd0, ARREADY}, 32'd0);
    chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
    chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_led", {28'd0, LED}, 32'd0);
    repeat (6) step();
    rst = 0;
    step();
    chk("post_rst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

    // Vector table: write then read back
    for (int i = 0; i < 10; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 0);
      axi_read(vecs[i].addr, 0, d);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      if (i == 3) chk("led_after_seq", {28'd0, LED}, 32'h1);
    end
    chk("led_after_table", {28'd0, LED}, 32'h1);
    for (int r = 0; r < 4; r++) read_check(4'(r * 4), 0);

    // Backpressure on both response channels; blocked second write must not land
    axi_write(4'h8, 32'h55AA_55AA, 4'hF, 0, 0, 5);
    read_check(4'hC, 0);
    read_check(4'h8, 5);

    // Read accepted on the same edge as a write commit to the same register
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    AWADDR = 4'h0; WDATA = 32'h5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    ARADDR = 4'h0; ARVALID = 1; RREADY = 0;
    chk("coll_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
    step();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("coll_bvalid", {31'd0, BVALID}, 32'd1);
    chk("coll_rvalid", {31'd0, RVALID}, 32'd1);
    chk("coll_old_value", RDATA, 32'h1);
    chk("coll_led", {28'd0, LED}, 32'h5);
    RREADY = 1;
    step();
    chk("coll_done", {30'd0, BVALID, RVALID}, 32'd0);
    RREADY = 0; BREADY = 0;
    model[0] = 32'h5;
    read_check(4'h0, 0);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        chk("rand_led", {28'd0, LED}, {28'd0, model[0][3:0]});
      end else begin
        read_check(4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end
    end

    // Reset while a write response is pending
    AWADDR = 4'h4; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    step();
    AWVALID = 0; WVALID = 0;
    chk("pre_rst_bvalid", {31'd0, BVALID}, 32'd1);
    #2 rst = 1;
    #1;
    chk("midrst_bvalid", {31'd0, BVALID}, 32'd0);
    chk("midrst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    chk("midrst_led", {28'd0, LED}, 32'd0);
    chk("midrst_rdata", RDATA, 32'd0);
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    step();
    chk("rerst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
    for (int r = 0; r < 4; r++) read_check(4'(r * 4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
